// File: rtl/uart_rx_word_pkg.sv
// Shared types for the word-assembling UART receiver: byte-FSM states,
// the byte-level result record and the byte-lane placement helper.
package uart_rx_word_pkg;

  localparam int DEF_CLKS_PER_BIT = 625;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       vld;   // good byte, 1-cycle strobe
    logic       ferr;  // stop bit sampled low, 1-cycle strobe
    logic [7:0] data;
  } rx_byte_t;

  // Byte lane inside the word for the idx-th received byte.
  function automatic int byte_slot(int idx, int nbytes, bit msb_first);
    return msb_first ? (nbytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling. Emits a byte strobe or a frame-error strobe.
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  output rx_byte_t rx_byte,
  output logic     idle
);

  localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state;
  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_s = sync[1];
  assign idle = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_byte <= '0;
    end else begin
      sync         <= {sync[0], rx};
      rx_prev      <= rx_s;
      rx_byte.vld  <= 1'b0;
      rx_byte.ferr <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s) state <= ST_START;
        end
        ST_START: begin
          // Line back high at mid start bit is a glitch, not a frame.
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else cnt <= cnt + 1'b1;
        end
        ST_DATA: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else cnt <= cnt + 1'b1;
        end
        ST_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte.vld  <= 1'b1;
              rx_byte.data <= shreg;
            end else begin
              rx_byte.ferr <= 1'b1;
            end
            state <= ST_CLEANUP;
          end else cnt <= cnt + 1'b1;
        end
        ST_CLEANUP: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: packs WORD_BYTES bytes into one word with selectable
// byte order, inter-byte timeout, framing-error drop and ready/valid output.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int WORD_BYTES   = 4,
  parameter int MSB_FIRST    = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    uart_rx,
  input  logic                    i_ready,
  output logic                    o_datavalid,
  output logic [8*WORD_BYTES-1:0] dataout,
  output logic                    o_busy,
  output logic                    o_frameerr,
  output logic                    o_timeout,
  output logic                    o_overrun
);

  localparam int            IW    = $clog2(WORD_BYTES + 1);
  localparam int            TMAX  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW    = $clog2(TMAX + 1);
  localparam logic [IW-1:0] LAST  = IW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TMAX - 1);

  rx_byte_t rx_byte;
  logic     byte_idle;

  logic [IW-1:0]                 idx;
  logic [TW-1:0]                 tcnt;
  logic [WORD_BYTES-1:0][7:0]    word_buf;
  logic [WORD_BYTES-1:0][7:0]    asm_word;
  logic                          word_done;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (i_clk),
    .rst_n  (i_rstn),
    .rx     (uart_rx),
    .rx_byte(rx_byte),
    .idle   (byte_idle)
  );

  // Word as it stands with the current strobed byte merged into its lane.
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    localparam int SLOT = byte_slot(k, WORD_BYTES, MSB_FIRST != 0);
    assign asm_word[SLOT] = (idx == IW'(k)) ? rx_byte.data : word_buf[SLOT];
  end

  assign word_done = rx_byte.vld && (idx == LAST);
  assign o_busy    = !byte_idle || (idx != '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      idx         <= '0;
      tcnt        <= '0;
      word_buf    <= '0;
      dataout     <= '0;
      o_datavalid <= 1'b0;
      o_frameerr  <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frameerr <= rx_byte.ferr;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;

      if (rx_byte.ferr) begin
        idx <= '0;
      end else if (rx_byte.vld) begin
        word_buf <= asm_word;
        idx      <= (idx == LAST) ? '0 : idx + 1'b1;
      end

      // Strobes only occur outside IDLE, so this never races the byte path.
      if (byte_idle && (idx != '0)) begin
        if (tcnt == TLAST) begin
          tcnt      <= '0;
          idx       <= '0;
          o_timeout <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end

      if (word_done) begin
        if (o_datavalid && !i_ready) begin
          o_overrun <= 1'b1;
        end else begin
          dataout     <= asm_word;
          o_datavalid <= 1'b1;
        end
      end else if (o_datavalid && i_ready) begin
        o_datavalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: three configurations on separate serial lines,
// scoreboard of expected words popped on each ready/valid transfer.
module tb_uart_rx_word;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  rx;
  logic [2:0]  rdy;
  logic [2:0]  vld, busy, ferr, tout, ovr;
  logic [31:0] dout_a, dout_b;
  logic [15:0] dout_c;
  logic [31:0] dout [3];

  int total = 0;
  int bad   = 0;
  int n_ferr [3];
  int n_to   [3];
  int n_ov   [3];

  logic [31:0] q0[$], q1[$], q2[$];

  always #20 clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .MSB_FIRST(1), .TIMEOUT_BITS(TOB)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .uart_rx(rx[0]), .i_ready(rdy[0]),
    .o_datavalid(vld[0]), .dataout(dout_a), .o_busy(busy[0]),
    .o_frameerr(ferr[0]), .o_timeout(tout[0]), .o_overrun(ovr[0]));

  uart_rx_word #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .MSB_FIRST(0), .TIMEOUT_BITS(TOB)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .uart_rx(rx[1]), .i_ready(rdy[1]),
    .o_datavalid(vld[1]), .dataout(dout_b), .o_busy(busy[1]),
    .o_frameerr(ferr[1]), .o_timeout(tout[1]), .o_overrun(ovr[1]));

  uart_rx_word #(.CLKS_PER_BIT(CPB), .WORD_BYTES(2), .MSB_FIRST(1), .TIMEOUT_BITS(TOB)) dut_c (
    .i_clk(clk), .i_rstn(rstn), .uart_rx(rx[2]), .i_ready(rdy[2]),
    .o_datavalid(vld[2]), .dataout(dout_c), .o_busy(busy[2]),
    .o_frameerr(ferr[2]), .o_timeout(tout[2]), .o_overrun(ovr[2]));

  assign dout[0] = dout_a;
  assign dout[1] = dout_b;
  assign dout[2] = {16'h0, dout_c};

  function automatic void push(int d, logic [31:0] w);
    case (d)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qpop(int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    for (int d = 0; d < 3; d++) begin
      if (ferr[d]) n_ferr[d]++;
      if (tout[d]) n_to[d]++;
      if (ovr[d])  n_ov[d]++;
      if (vld[d] && rdy[d]) begin
        if (qsize(d) == 0) begin
          total++;
          bad++;
          $display("FAIL stray_word dut%0d: got %h want none", d, dout[d]);
        end else begin
          e = qpop(d);
          chk($sformatf("word_dut%0d", d), dout[d], e);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(int d, logic [7:0] b, logic stop);
    rx[d] = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx[d] = b[i];
      cyc(CPB);
    end
    rx[d] = stop;
    cyc(CPB);
    rx[d] = 1'b1;
    cyc(CPB);
  endtask

  // Bytes go out in the order they are written in the literal, left first.
  task automatic send_word(int d, logic [31:0] w, int nb);
    for (int i = 0; i < nb; i++) send_byte(d, w[8*(nb-1-i) +: 8], 1'b1);
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 40 * CPB) begin
      cyc(1);
      n++;
    end
    total++;
    if (qsize(d) != 0) begin
      bad++;
      $display("FAIL drain_dut%0d: got %0d pending want 0", d, qsize(d));
    end
  endtask

  typedef struct {
    int          d;
    int          nb;
    logic [31:0] bytes;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      n_ferr[d] = 0;
      n_to[d]   = 0;
      n_ov[d]   = 0;
    end
    rx  = 3'b111;
    rdy = 3'b111;

    vt[0] = '{0, 4, 32'hB10A7912, 32'hB10A7912};
    vt[1] = '{1, 4, 32'hB10A7912, 32'h12790AB1};
    vt[2] = '{2, 2, 32'h00000010, 32'h00000010};
    vt[3] = '{2, 2, 32'h00005060, 32'h00005060};
    vt[4] = '{0, 4, 32'hFF00A55A, 32'hFF00A55A};
    vt[5] = '{1, 4, 32'h01020304, 32'h04030201};

    cyc(3);
    chk("rst_valid", {29'b0, vld}, 32'h0);
    chk("rst_busy",  {29'b0, busy}, 32'h0);
    chk("rst_pulses", {23'b0, ferr, tout, ovr}, 32'h0);
    chk("rst_dout_a", dout[0], 32'h0);
    chk("rst_dout_c", dout[2], 32'h0);
    rstn = 1'b1;
    cyc(2 * CPB);

    for (int i = 0; i < 6; i++) begin
      push(vt[i].d, vt[i].exp);
      send_word(vt[i].d, vt[i].bytes, vt[i].nb);
      drain(vt[i].d);
    end

    // Partial word abandoned by a long idle gap.
    send_byte(0, 8'hB1, 1'b1);
    send_byte(0, 8'h0A, 1'b1);
    cyc(21 * CPB);
    chk("timeout_count", n_to[0], 1);
    chk("timeout_busy", {31'b0, busy[0]}, 32'h0);
    push(0, 32'h00105060);
    send_word(0, 32'h00105060, 4);
    drain(0);

    // Bad stop bit mid-word drops the partial word.
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    send_byte(0, 8'h33, 1'b0);
    cyc(CPB);
    chk("frameerr_count", n_ferr[0], 1);
    chk("frameerr_busy", {31'b0, busy[0]}, 32'h0);
    push(0, 32'h44556677);
    send_word(0, 32'h44556677, 4);
    drain(0);

    // Output register full: second word dropped with overrun.
    rdy[0] = 1'b0;
    push(0, 32'hAABBCCDD);
    send_word(0, 32'hAABBCCDD, 4);
    send_word(0, 32'h01020304, 4);
    cyc(CPB);
    chk("overrun_count", n_ov[0], 1);
    chk("overrun_valid", {31'b0, vld[0]}, 32'h1);
    chk("overrun_held", dout[0], 32'hAABBCCDD);
    rdy[0] = 1'b1;
    cyc(1);
    chk("accept_valid_fall", {31'b0, vld[0]}, 32'h0);
    chk("accept_popped", qsize(0), 0);

    // Short low glitch on an idle line must not start a frame.
    rx[0] = 1'b0;
    cyc(4);
    rx[0] = 1'b1;
    cyc(2 * CPB);
    chk("glitch_busy", {31'b0, busy[0]}, 32'h0);
    chk("glitch_ferr", n_ferr[0], 1);

    // Reset in the middle of a byte, with a partial word held.
    send_byte(0, 8'h99, 1'b1);
    rx[0] = 1'b0;
    cyc(3 * CPB);
    chk("pre_reset_busy", {31'b0, busy[0]}, 32'h1);
    rstn = 1'b0;
    #5;
    chk("midrst_dout", dout[0], 32'h0);
    chk("midrst_flags", {26'b0, vld[0], busy[0], ferr[0], tout[0], ovr[0], 1'b0}, 32'h0);
    rx[0] = 1'b1;
    cyc(2);
    rstn = 1'b1;
    cyc(2 * CPB);
    push(0, 32'h5AA5C33C);
    send_word(0, 32'h5AA5C33C, 4);
    drain(0);

    cyc(2 * CPB);
    chk("final_ferr_a", n_ferr[0], 1);
    chk("final_to_a", n_to[0], 1);
    chk("final_ov_a", n_ov[0], 1);
    chk("final_events_b", n_ferr[1] + n_to[1] + n_ov[1], 0);
    chk("final_events_c", n_ferr[2] + n_to[2] + n_ov[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
